ireg_queue: RTL and testbench

- Parametrised instruction register with a small prefetch queue, for the Lab9 simple processor datapath.
- Instruction words are pushed by the fetch side and held in a DEPTH-entry FIFO.
- On an advance request, the oldest word is moved into the current-instruction register, which drives the decoder.
- The opcode and register fields of the current instruction are broken out as separate outputs.

---
 rtl/ireg_queue_if.sv | 55 +++++
 rtl/ireg_queue.sv | 120 ++++++++++++
 tb/tb_ireg_queue.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ireg_queue_if.sv
// ---------------------------------------------------------------------------
// ireg_queue_if
//   Bundles the fetch-side and decoder-side signals of the instruction
//   register / prefetch queue.
//
//   master : the fetch/control side. It drives IN, WE, ADV and FLUSH and
//            observes the instruction register and queue status.
//   slave  : the ireg_queue block itself.
//
//   Signals
//     IN     [WIDTH]   instruction word to enqueue
//     WE               push IN into the queue
//     ADV              load the next instruction into OUT
//     FLUSH            discard queued words and invalidate OUT
//     OUT    [WIDTH]   current instruction register
//     VALID            OUT holds a live instruction
//     OPC    [OPW]     opcode field of OUT (MSBs)
//     RX     [FLW]     first register field of OUT
//     RY     [FLW]     second register field of OUT (LSBs)
//     COUNT  [CW]      queued words, not counting OUT
//     EMPTY / FULL     COUNT == 0 / COUNT == DEPTH
//     OVF              sticky: a push was dropped while full
// ---------------------------------------------------------------------------
interface ireg_queue_if #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4,
   parameter int OPW   = 3,
   parameter int FLW   = 3
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] IN;
   logic             WE;
   logic             ADV;
   logic             FLUSH;
   logic [WIDTH-1:0] OUT;
   logic             VALID;
   logic [OPW-1:0]   OPC;
   logic [FLW-1:0]   RX;
   logic [FLW-1:0]   RY;
   logic [CW-1:0]    COUNT;
   logic             EMPTY;
   logic             FULL;
   logic             OVF;

   modport master (
      output IN, WE, ADV, FLUSH,
      input  OUT, VALID, OPC, RX, RY, COUNT, EMPTY, FULL, OVF
   );

   modport slave (
      input  IN, WE, ADV, FLUSH,
      output OUT, VALID, OPC, RX, RY, COUNT, EMPTY, FULL, OVF
   );
endinterface

// File: rtl/ireg_queue.sv
// ---------------------------------------------------------------------------
// ireg_queue
//   Instruction register fed by a DEPTH-entry prefetch FIFO. Fetch pushes
//   words with WE; ADV moves the oldest queued word into OUT, which drives
//   the decoder. When the queue is empty, ADV together with WE bypasses the
//   queue and loads IN straight into OUT. FLUSH clears everything.
//
//   All state changes on the FALLING edge of CLK; RST_N is asynchronous,
//   active low.
//
//   Ports
//     CLK    clock (negedge active)
//     RST_N  asynchronous active-low reset
//     bus    ireg_queue_if.slave: IN/WE/ADV/FLUSH in, OUT/VALID/OPC/RX/RY/
//            COUNT/EMPTY/FULL/OVF out
// ---------------------------------------------------------------------------
module ireg_queue #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4,
   parameter int OPW   = 3,
   parameter int FLW   = 3
) (
   input  logic        CLK,
   input  logic        RST_N,
   ireg_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // queue storage and bookkeeping
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;

   // instruction register
   logic [WIDTH-1:0] out_r;
   logic             valid_r;
   logic             ovf_r;

   // per-edge decisions
   logic empty;
   logic full;
   logic pop;      // head word moves into OUT
   logic push;     // IN is written at the tail
   logic bypass;   // IN goes straight to OUT, queue untouched
   logic drop;     // push refused because the queue is full

   always_comb begin
      empty  = (count == '0);
      full   = (count == CW'(DEPTH));
      pop    = !bus.FLUSH && bus.ADV && !empty;
      bypass = !bus.FLUSH && bus.ADV && empty && bus.WE;
      // A push alongside a pop always fits: the pop frees the slot the
      // push needs, so this is legal even when full.
      push   = !bus.FLUSH && bus.WE && (pop || (!bus.ADV && !full));
      drop   = !bus.FLUSH && bus.WE && !bus.ADV && full;
   end

   // Storage carries no reset; entries are only ever read after being
   // written since the last reset/flush.
   always_ff @(negedge CLK) begin
      if (RST_N && push)
         mem[wr_ptr] <= bus.IN;
   end

   always_ff @(negedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         out_r   <= '0;
         valid_r <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (bus.FLUSH) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         out_r   <= '0;
         valid_r <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         // pointers are a power-of-two width, so wrap is natural overflow
         if (push)
            wr_ptr <= wr_ptr + PW'(1);

         if (pop) begin
            out_r   <= mem[rd_ptr];
            valid_r <= 1'b1;
            rd_ptr  <= rd_ptr + PW'(1);
         end else if (bypass) begin
            out_r   <= bus.IN;
            valid_r <= 1'b1;
         end else if (bus.ADV) begin
            // advance with nothing to load: OUT keeps its stale value
            valid_r <= 1'b0;
         end

         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);

         if (drop)
            ovf_r <= 1'b1;
      end
   end

   // decoder-facing outputs, combinational from the registers
   assign bus.OUT   = out_r;
   assign bus.VALID = valid_r;
   assign bus.OPC   = out_r[WIDTH-1 -: OPW];
   assign bus.RX    = out_r[WIDTH-OPW-1 -: FLW];
   assign bus.RY    = out_r[FLW-1:0];
   assign bus.COUNT = count;
   assign bus.EMPTY = empty;
   assign bus.FULL  = full;
   assign bus.OVF   = ovf_r;

endmodule

// File: tb/tb_ireg_queue.sv
// ---------------------------------------------------------------------------
// tb_ireg_queue
//   Stimulus computes the expected post-edge state from a queue-based model
//   and pushes it into a scoreboard; a monitor pops one entry at every rising
//   edge (half a cycle after the active falling edge) and compares.
// ---------------------------------------------------------------------------
module tb_ireg_queue;
   localparam int WIDTH = 9;
   localparam int DEPTH = 4;
   localparam int OPW   = 3;
   localparam int FLW   = 3;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;

   always #5 CLK = ~CLK;

   ireg_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPW(OPW), .FLW(FLW)) bus ();

   ireg_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPW(OPW), .FLW(FLW)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [WIDTH-1:0] out;
      logic             valid;
      int               count;
      logic             ovf;
   } snap_t;

   snap_t exp_q[$];
   int checks = 0;
   int errors = 0;

   // reference model
   logic [WIDTH-1:0] mq[$];
   logic [WIDTH-1:0] m_out   = '0;
   logic             m_valid = 1'b0;
   logic             m_ovf   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state(input string tag, input snap_t e);
      chk({tag, "_out"},   32'(bus.OUT),   32'(e.out));
      chk({tag, "_valid"}, 32'(bus.VALID), 32'(e.valid));
      chk({tag, "_count"}, 32'(bus.COUNT), 32'(e.count));
      chk({tag, "_ovf"},   32'(bus.OVF),   32'(e.ovf));
      chk({tag, "_empty"}, 32'(bus.EMPTY), 32'(e.count == 0));
      chk({tag, "_full"},  32'(bus.FULL),  32'(e.count == DEPTH));
      chk({tag, "_opc"},   32'(bus.OPC),   32'(e.out[WIDTH-1 -: OPW]));
      chk({tag, "_rx"},    32'(bus.RX),    32'(e.out[WIDTH-OPW-1 -: FLW]));
      chk({tag, "_ry"},    32'(bus.RY),    32'(e.out[FLW-1:0]));
   endtask

   function automatic snap_t cur_model();
      snap_t s;
      s.out   = m_out;
      s.valid = m_valid;
      s.count = mq.size();
      s.ovf   = m_ovf;
      return s;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_out   = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
   endtask

   task automatic model_step(input logic [WIDTH-1:0] in, input logic we, input logic adv,
                             input logic flush);
      if (flush) begin
         model_reset();
      end else if (adv) begin
         if (mq.size() > 0) begin
            m_out   = mq.pop_front();
            m_valid = 1'b1;
            if (we) mq.push_back(in);
         end else if (we) begin
            m_out   = in;
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
      end else if (we) begin
         if (mq.size() < DEPTH) mq.push_back(in);
         else                   m_ovf = 1'b1;
      end
   endtask

   // monitor: one scoreboard entry per active edge, sampled half a cycle later
   snap_t mon_e;
   always @(posedge CLK) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check_state("edge", mon_e);
      end
   end

   task automatic cyc(input logic [WIDTH-1:0] in, input logic we, input logic adv,
                      input logic flush);
      @(posedge CLK);
      #1;
      bus.IN    = in;
      bus.WE    = we;
      bus.ADV   = adv;
      bus.FLUSH = flush;
      model_step(in, we, adv, flush);
      exp_q.push_back(cur_model());
   endtask

   task automatic push(input logic [WIDTH-1:0] w); cyc(w, 1'b1, 1'b0, 1'b0); endtask
   task automatic adv();                           cyc('0, 1'b0, 1'b1, 1'b0); endtask

   // reset asserted between edges; outputs must change before any clock edge
   task automatic mid_reset();
      @(posedge CLK);
      #2;
      RST_N     = 1'b0;
      bus.WE    = 1'b0;
      bus.ADV   = 1'b0;
      bus.FLUSH = 1'b0;
      model_reset();
      #1;
      check_state("async_rst", cur_model());
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
   endtask

   initial begin
      bus.IN    = '0;
      bus.WE    = 1'b0;
      bus.ADV   = 1'b0;
      bus.FLUSH = 1'b0;
      #1;
      check_state("reset", cur_model());
      @(posedge CLK);
      #1;
      RST_N = 1'b1;

      // 1: basic push then advance, field breakout on 10E
      push(9'h10E); push(9'h0E1); push(9'h0ED);
      adv(); adv(); adv();
      adv();

      // 2: overfill, the fifth word is dropped
      for (int i = 0; i < 5; i++) push(WIDTH'(9'h011 + i));
      for (int i = 0; i < 5; i++) adv();

      // 3: push and advance together while full
      for (int i = 0; i < 4; i++) push(WIDTH'(9'h031 + i));
      cyc(9'h1FF, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) adv();

      // 4: bypass on an empty queue, then an empty advance
      cyc(9'h0A5, 1'b1, 1'b1, 1'b0);
      adv();

      // 5: flush beats WE and ADV, then pointer wrap
      for (int i = 0; i < 5; i++) push(WIDTH'(9'h051 + i));
      adv();
      cyc(9'h077, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) begin
         push(WIDTH'(9'h101 + 7 * i));
         adv();
      end

      // 6: asynchronous reset mid-stream
      push(9'h123); push(9'h045); adv();
      mid_reset();
      push(9'h1AB); push(9'h0CD); adv(); adv(); adv();

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            mid_reset();
         end else begin
            cyc(WIDTH'($urandom), ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 40),
                ($urandom_range(0, 99) < 3));
         end
      end

      cyc('0, 1'b0, 1'b0, 1'b0);
      cyc('0, 1'b0, 1'b0, 1'b0);
      @(posedge CLK);
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
